mips_sc_core: RTL and testbench
===============================

Name: mips_sc_core

Overview:
- Single-cycle 32-bit MIPS-subset processor core, one instruction per clock.
- Drives a byte-addressed instruction address to an external combinational instruction memory.
- Accesses an external data memory: combinational read, write on rising clk.
- Top-level CPU of the single-cycle system; instruction and data memories are separate blocks.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RF_DEPTH, 32, number of general registers (fixed MIPS register file).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_adr  output  32  byte address of the current instruction (= PC).
- inst  input  32  instruction word returned combinationally for inst_adr.
- data_adr  output  32  data memory byte address (ALU result).
- data_out  input  32  read data from data memory (valid combinationally when mem_read=1).
- data_in  output  32  store data to data memory (rt register value).
- mem_read  output  1  high for lw.
- mem_write  output  1  high for sw; memory writes on the rising clk edge.

Behaviour:
- Reset (rst=0, async):
  - PC=RESET_PC; all 32 registers cleared to 0.
  - mem_read=0, mem_write=0 are forced while rst=0.
  - data_adr and data_in follow the combinational datapath.
- Supported instructions:
  - R-type (op 000000): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- Arithmetic:
  - 32-bit two's complement; overflow ignored (add/addi wrap, no trap).
  - slt/slti compare signed; result is 1 or 0.
  - Immediates for addi, slti, lw, sw and beq are sign-extended.
- Register file:
  - Two combinational read ports (rs, rt), one write port on rising clk.
  - $0 always reads 0; writes to $0 are discarded.
  - Reading a register written in the same cycle returns the old value (no bypass needed in single cycle).
- Destinations and write data:
  - R-type writes rd; addi, slti and lw write rt; jal writes $31 with PC+4.
  - lw write data = data_out; otherwise ALU result.
- Next PC, selected in this priority order:
  - jr: rs value.
  - j/jal: {PC+4[31:28], inst[25:0], 2'b00}.
  - beq taken (rs==rt): PC+4 + (sext(imm)<<2).
  - Otherwise: PC+4.
- Memory interface:
  - data_adr = rs + sext(imm) for lw/sw; data_in = rt.
  - mem_read and mem_write are purely combinational decodes of inst and are never both high.
- Undefined opcode or funct: behaves as NOP (no register or memory write, PC+4).
- PC wraps modulo 2^32.
- Reset mid-program: PC and registers clear immediately; no write is committed in the cycle where rst is low at the edge.

Optional Feature:
- Macro MIPS_SC_BNE_EN:
  - When defined, adds bne (op 0x05): branch when rs!=rt, same target calculation as beq.
  - When undefined, op 0x05 decodes as NOP.

Decomposition:
- Package mips_sc_pkg holds:
  - opcode and funct localparams;
  - the ALU-operation enum (ADD, SUB, AND, OR, SLT);
  - the control-signal struct (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, jal, jr, alu_op).
- Natural sub-module: mips_sc_alu (combinational, two 32-bit operands and op → result, zero flag).
- Register file and decoder stay inside the core.

Test Plan:
- Reset then release:
  - inst_adr=0 during reset; advances 0,4,8,… each clk.
  - mem_write=0 throughout reset.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1:
  - $3=2, $4=8, $5=1.
  - addi $0,$0,7 leaves $0=0.
- sw $1,8($0); lw $6,8($0):
  - sw cycle: mem_write=1, data_adr=8, data_in=5.
  - lw cycle: mem_read=1; $6=5.
- beq $1,$1,+2 at PC=0x20 → next PC=0x2C.
- beq $1,$2 (unequal) → next PC=0x24.
- jal 0x40 at PC=0x10 → PC=0x100, $31=0x14; jr $31 → PC=0x14.
- Assert rst mid-program → PC=0 and registers=0 asynchronously.
- With MIPS_SC_BNE_EN, bne $1,$2,+1 at 0x30 → PC=0x38; without the macro → PC=0x34, no state change.

Source files
------------

// File: rtl/mips_sc_pkg.sv
// Shared definitions for the single-cycle MIPS-subset core: opcodes, functs,
// ALU operations and the decoded control word.
package mips_sc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    jal;
        logic    jr;
        alu_op_t alu_op;
    } ctrl_t;

    // Decoded control for anything unrecognised: no writes, fall through to PC+4.
    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};

    function automatic ctrl_t r_type_ctrl(input alu_op_t op);
        ctrl_t c;
        c           = CTRL_NOP;
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = op;
        return c;
    endfunction

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_sc_alu.sv
// Combinational 32-bit ALU for the single-cycle core; zero flag feeds the
// branch comparison.
module mips_sc_alu
    import mips_sc_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_sc_core.sv
// Single-cycle MIPS-subset core with separate instruction and data memory ports.
// Define MIPS_SC_BNE_EN to add the bne instruction (otherwise op 0x05 is a NOP).
module mips_sc_core
    import mips_sc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_adr,
    input  logic [31:0] inst,
    output logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] imm_sext;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [31:0] wr_data;
    logic        alu_zero;
    logic        branch_taken;
    ctrl_t       ctrl;

    logic [31:0] regs [RF_DEPTH];

    assign opcode   = inst[31:26];
    assign rs_addr  = inst[25:21];
    assign rt_addr  = inst[20:16];
    assign rd_addr  = inst[15:11];
    assign funct    = inst[5:0];
    assign imm_sext = sign_ext16(inst[15:0]);

    // The shift-amount field has no consumer in this instruction subset.
    logic unused_shamt;
    assign unused_shamt = ^inst[10:6];

    // NOTE: every field gets a default before the case so no path leaves ctrl
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl = r_type_ctrl(ALU_ADD);
                    FN_SUB:  ctrl = r_type_ctrl(ALU_SUB);
                    FN_AND:  ctrl = r_type_ctrl(ALU_AND);
                    FN_OR:   ctrl = r_type_ctrl(ALU_OR);
                    FN_SLT:  ctrl = r_type_ctrl(ALU_SLT);
                    FN_JR:   ctrl.jr = 1'b1;
                    default: ctrl = CTRL_NOP;
                endcase
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_SLT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
`ifdef MIPS_SC_BNE_EN
            OP_BNE: begin
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
`else
            OP_BNE: ctrl = CTRL_NOP;
`endif
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.jal       = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    assign rs_val = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_val = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
    assign alu_b  = ctrl.alu_src ? imm_sext : rt_val;

    mips_sc_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .op     (ctrl.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        wr_addr = rt_addr;
        if (ctrl.jal) begin
            wr_addr = RA_REG;
        end else if (ctrl.reg_dst) begin
            wr_addr = rd_addr;
        end
    end

    assign wr_data = ctrl.jal        ? pc_plus4 :
                     ctrl.mem_to_reg ? data_out : alu_result;

    // NOTE: the whole register file is cleared on reset, so it is built from
    // flops rather than a RAM macro that has no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (ctrl.reg_write && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};
    assign branch_taken  = ctrl.branch & (ctrl.branch_ne ? ~alu_zero : alu_zero);

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jr) begin
            pc_next = rs_val;
        end else if (ctrl.jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign inst_adr  = pc;
    assign data_adr  = alu_result;
    assign data_in   = rt_val;
    assign mem_read  = ctrl.mem_read & rst;
    assign mem_write = ctrl.mem_write & rst;

endmodule

// File: tb/tb_mips_sc_core.sv
// Directed self-checking bench for mips_sc_core: the bench drives each
// instruction word and observes PC, memory strobes and store data.
module tb_mips_sc_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_adr;
    logic [31:0] inst;
    logic [31:0] data_adr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dmem [16];

`ifdef MIPS_SC_BNE_EN
    localparam logic [31:0] B = 32'h38;
`else
    localparam logic [31:0] B = 32'h34;
`endif

    mips_sc_core #(
        .RESET_PC (32'h0000_0000),
        .RF_DEPTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .inst_adr  (inst_adr),
        .inst      (inst),
        .data_adr  (data_adr),
        .data_out  (data_out),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_out = dmem[data_adr[5:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[data_adr[5:2]] <= data_in;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction in the low clock phase and confirm the PC it sits at.
    task automatic issue(input logic [31:0] ins, input logic [31:0] exp_pc);
        @(negedge clk);
        inst = ins;
        #1;
        check("pc", inst_adr, exp_pc);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        rst_n = 1'b0;
        inst  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);

        @(negedge clk); #1;
        check("reset_pc", inst_adr, 32'h0);
        check("reset_mem_write", {31'd0, mem_write}, 32'd0);
        inst = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
        @(negedge clk); #1;
        check("reset_pc_hold", inst_adr, 32'h0);
        check("reset_mem_read", {31'd0, mem_read}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        inst  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        #1;
        check("first_pc", inst_adr, 32'h0);

        issue(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), 32'h04);
        issue(enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h08);
        issue(enc_r(5'd1, 5'd2, 5'd4, 6'h22), 32'h0C);
        issue(enc_r(5'd2, 5'd1, 5'd5, 6'h2A), 32'h10);
        issue(enc_i(6'h08, 5'd0, 5'd0, 16'd7), 32'h14);

        issue(enc_i(6'h2B, 5'd0, 5'd1, 16'd8), 32'h18);
        check("sw_mem_write", {31'd0, mem_write}, 32'd1);
        check("sw_mem_read", {31'd0, mem_read}, 32'd0);
        check("sw_data_adr", data_adr, 32'd8);
        check("sw_data_in", data_in, 32'd5);

        issue(enc_i(6'h23, 5'd0, 5'd6, 16'd8), 32'h1C);
        check("lw_mem_read", {31'd0, mem_read}, 32'd1);
        check("lw_mem_write", {31'd0, mem_write}, 32'd0);
        check("lw_data_adr", data_adr, 32'd8);

        issue(enc_i(6'h04, 5'd1, 5'd1, 16'd2), 32'h20);
        issue(enc_i(6'h04, 5'd1, 5'd2, 16'd5), 32'h2C);
        issue(enc_i(6'h05, 5'd1, 5'd2, 16'd1), 32'h30);

        issue(enc_i(6'h2B, 5'd0, 5'd3, 16'd0), B);
        check("add_result", data_in, 32'd2);
        issue(enc_i(6'h2B, 5'd0, 5'd4, 16'd4), B + 32'h04);
        check("sub_result", data_in, 32'd8);
        issue(enc_i(6'h2B, 5'd0, 5'd5, 16'd12), B + 32'h08);
        check("slt_result", data_in, 32'd1);
        issue(enc_i(6'h2B, 5'd0, 5'd6, 16'd16), B + 32'h0C);
        check("lw_result", data_in, 32'd5);
        issue(enc_i(6'h2B, 5'd0, 5'd0, 16'd20), B + 32'h10);
        check("zero_reg", data_in, 32'd0);
        issue(enc_i(6'h2B, 5'd1, 5'd2, 16'hFFFC), B + 32'h14);
        check("neg_offset_adr", data_adr, 32'd1);
        check("addi_neg", data_in, 32'hFFFF_FFFD);

        issue(enc_i(6'h0A, 5'd2, 5'd7, 16'd0), B + 32'h18);
        issue(enc_i(6'h0A, 5'd1, 5'd8, 16'hFFFF), B + 32'h1C);
        issue(enc_r(5'd1, 5'd2, 5'd9, 6'h24), B + 32'h20);
        issue(enc_r(5'd1, 5'd2, 5'd10, 6'h25), B + 32'h24);
        issue(enc_i(6'h2B, 5'd0, 5'd7, 16'd0), B + 32'h28);
        check("slti_true", data_in, 32'd1);
        issue(enc_i(6'h2B, 5'd0, 5'd8, 16'd0), B + 32'h2C);
        check("slti_false", data_in, 32'd0);
        issue(enc_i(6'h2B, 5'd0, 5'd9, 16'd0), B + 32'h30);
        check("and_result", data_in, 32'd5);
        issue(enc_i(6'h2B, 5'd0, 5'd10, 16'd0), B + 32'h34);
        check("or_result", data_in, 32'hFFFF_FFFD);

        issue(enc_i(6'h3F, 5'd0, 5'd1, 16'd8), B + 32'h38);
        check("undef_op_write", {31'd0, mem_write}, 32'd0);
        check("undef_op_read", {31'd0, mem_read}, 32'd0);
        issue(enc_r(5'd1, 5'd2, 5'd1, 6'h3F), B + 32'h3C);
        issue(enc_i(6'h2B, 5'd0, 5'd1, 16'd0), B + 32'h40);
        check("undef_no_write", data_in, 32'd5);

        issue(enc_j(6'h03, 26'h40), B + 32'h44);
        issue(enc_i(6'h2B, 5'd0, 5'd31, 16'd0), 32'h100);
        check("jal_link", data_in, B + 32'h48);
        issue(enc_r(5'd31, 5'd0, 5'd0, 6'h08), 32'h104);
        issue(enc_i(6'h08, 5'd0, 5'd11, 16'hFFFC), B + 32'h48);
        issue(enc_r(5'd11, 5'd0, 5'd0, 6'h08), B + 32'h4C);
        issue(32'h0, 32'hFFFF_FFFC);
        issue(enc_j(6'h02, 26'h10), 32'h0);
        issue(enc_i(6'h2B, 5'd0, 5'd1, 16'd0), 32'h40);
        check("pre_reset_store", data_in, 32'd5);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pc", inst_adr, 32'h0);
        check("async_reset_mem_write", {31'd0, mem_write}, 32'd0);
        inst = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        @(negedge clk); #1;
        check("reset_hold_pc", inst_adr, 32'h0);
        rst_n = 1'b1;
        inst  = enc_i(6'h2B, 5'd0, 5'd1, 16'd0);
        #1;
        check("reset_cleared_r1", data_in, 32'd0);
        issue(enc_i(6'h2B, 5'd0, 5'd2, 16'd0), 32'h04);
        check("reset_cleared_r2", data_in, 32'd0);
        issue(enc_i(6'h08, 5'd0, 5'd1, 16'd9), 32'h08);
        issue(enc_i(6'h2B, 5'd0, 5'd1, 16'd0), 32'h0C);
        check("post_reset_write", data_in, 32'd9);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
